// File: rtl/glitch_sweep.sv
// glitch_sweep: walks a (delay, width) grid and fires one glitch per point,
// each on a synchronized rising edge of the target trigger, paced by the
// glitch controller's ready.
`timescale 1ns/1ps
module glitch_sweep #(
    parameter int unsigned DELAY_W   = 16,
    parameter int unsigned WIDTH_W   = 8,
    parameter int unsigned TRIG_SYNC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DELAY_W-1:0] delay_start,
    input  logic [DELAY_W-1:0] delay_end,
    input  logic [DELAY_W-1:0] delay_step,
    input  logic [WIDTH_W-1:0] width_start,
    input  logic [WIDTH_W-1:0] width_end,
    input  logic [WIDTH_W-1:0] width_step,
    input  logic [7:0]         mode_in,
    input  logic               trigger,
    input  logic               glitch_ready,
    output logic               glitch_en,
    output logic [DELAY_W-1:0] glitch_delay,
    output logic [WIDTH_W-1:0] glitch_width,
    output logic [7:0]         glitch_mode,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [23:0]        attempt_cnt
);

    localparam int unsigned CNT_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [TRIG_SYNC-1:0] sync_q;
    logic                 trig_prev_q;

    logic [DELAY_W-1:0]   dly_start_q;
    logic [DELAY_W-1:0]   dly_end_q;
    logic [DELAY_W-1:0]   dly_step_q;
    logic [WIDTH_W-1:0]   wid_end_q;
    logic [WIDTH_W-1:0]   wid_step_q;

    logic                 en_q;
    logic [DELAY_W-1:0]   delay_q;
    logic [WIDTH_W-1:0]   width_q;
    logic [7:0]           mode_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 trig_rise;
    logic                 cfg_bad;
    logic [DELAY_W:0]     delay_sum_d;
    logic [WIDTH_W:0]     width_sum_d;
    logic                 delay_adv;
    logic                 width_adv;

    // Next grid point carries one extra bit so overflow reads as "past end"
    assign delay_sum_d = {1'b0, delay_q} + {1'b0, dly_step_q};
    assign width_sum_d = {1'b0, width_q} + {1'b0, wid_step_q};
    assign delay_adv   = (dly_step_q != '0) && (delay_sum_d <= {1'b0, dly_end_q});
    assign width_adv   = (wid_step_q != '0) && (width_sum_d <= {1'b0, wid_end_q});

    assign cfg_bad     = (delay_start > delay_end) || (width_start > width_end);
    assign trig_rise   = sync_q[TRIG_SYNC-1] & ~trig_prev_q;

    // Trigger synchronizer plus edge-detect history of the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[TRIG_SYNC-2:0], trigger};
            trig_prev_q <= sync_q[TRIG_SYNC-1];
        end
    end

    // Sweep sequencer with registered outputs; abort overrides every busy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dly_start_q <= '0;
            dly_end_q   <= '0;
            dly_step_q  <= '0;
            wid_end_q   <= '0;
            wid_step_q  <= '0;
            en_q        <= 1'b0;
            delay_q     <= '0;
            width_q     <= '0;
            mode_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (cfg_bad) begin
                                err_q <= 1'b1;
                            end else begin
                                dly_start_q <= delay_start;
                                dly_end_q   <= delay_end;
                                dly_step_q  <= delay_step;
                                wid_end_q   <= width_end;
                                wid_step_q  <= width_step;
                                delay_q     <= delay_start;
                                width_q     <= width_start;
                                mode_q      <= mode_in;
                                cnt_q       <= '0;
                                busy_q      <= 1'b1;
                                state_q     <= S_ARM;
                            end
                        end
                    end
                    S_ARM: begin
                        // edges seen while the controller is not ready are dropped
                        if (trig_rise && glitch_ready) begin
                            en_q    <= 1'b1;
                            state_q <= S_FIRE;
                            if (cnt_q != '1) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    S_FIRE: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (glitch_ready) begin
                            state_q <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        // delay is the inner axis, width the outer
                        if (delay_adv) begin
                            delay_q <= delay_sum_d[DELAY_W-1:0];
                            state_q <= S_ARM;
                        end else begin
                            delay_q <= dly_start_q;
                            if (width_adv) begin
                                width_q <= width_sum_d[WIDTH_W-1:0];
                                state_q <= S_ARM;
                            end else begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign glitch_en    = en_q;
    assign glitch_delay = delay_q;
    assign glitch_width = width_q;
    assign glitch_mode  = mode_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign attempt_cnt  = cnt_q;

endmodule

// File: tb/tb_glitch_sweep.sv
// tb_glitch_sweep: scoreboard-based bench for the glitch sweep sequencer.
`timescale 1ns/1ps
module tb_glitch_sweep;

    localparam int TRIG_SYNC = 2;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  w;
        logic [7:0]  m;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] delay_start;
    logic [15:0] delay_end;
    logic [15:0] delay_step;
    logic [7:0]  width_start;
    logic [7:0]  width_end;
    logic [7:0]  width_step;
    logic [7:0]  mode_in;
    logic        trigger;
    logic        glitch_ready;
    logic        glitch_en;
    logic [15:0] glitch_delay;
    logic [7:0]  glitch_width;
    logic [7:0]  glitch_mode;
    logic        busy;
    logic        done;
    logic        err;
    logic [23:0] attempt_cnt;

    logic        model_on;
    logic        model_rdy;
    logic        man_rdy;

    int          checks;
    int          errors;
    int          done_cnt;
    int          err_cyc;
    int          fire_cnt;
    exp_t        exp_q[$];
    exp_t        mon_e;

    assign glitch_ready = model_on ? model_rdy : man_rdy;

    glitch_sweep #(
        .DELAY_W  (16),
        .WIDTH_W  (8),
        .TRIG_SYNC(TRIG_SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .delay_start (delay_start),
        .delay_end   (delay_end),
        .delay_step  (delay_step),
        .width_start (width_start),
        .width_end   (width_end),
        .width_step  (width_step),
        .mode_in     (mode_in),
        .trigger     (trigger),
        .glitch_ready(glitch_ready),
        .glitch_en   (glitch_en),
        .glitch_delay(glitch_delay),
        .glitch_width(glitch_width),
        .glitch_mode (glitch_mode),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .attempt_cnt (attempt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // controller model: drops ready for three cycles after each fire
    initial begin
        model_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (model_on && glitch_en) begin
                model_rdy = 1'b0;
                repeat (3) @(negedge clk);
                model_rdy = 1'b1;
            end
        end
    end

    // scoreboard: every fire must match the oldest expected point
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (err) err_cyc++;
            if (glitch_en) begin
                fire_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_fire: glitch_en=1 delay=%0d width=%0d, required no fire",
                             glitch_delay, glitch_width);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({glitch_delay, glitch_width, glitch_mode} !== mon_e) begin
                        errors++;
                        $display("FAIL fire_point: got d=%0d w=%0d m=%0h, required d=%0d w=%0d m=%0h",
                                 glitch_delay, glitch_width, glitch_mode, mon_e.d, mon_e.w, mon_e.m);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1);
    end

    task automatic push_exp(input int d, input int w, input logic [7:0] m);
        exp_t e;
        e.d = 16'(d);
        e.w = 8'(w);
        e.m = m;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [15:0] ds, input logic [15:0] de, input logic [15:0] dst,
                            input logic [7:0] ws, input logic [7:0] we, input logic [7:0] wst,
                            input logic [7:0] m);
        @(negedge clk);
        delay_start = ds;
        delay_end   = de;
        delay_step  = dst;
        width_start = ws;
        width_end   = we;
        width_step  = wst;
        mode_in     = m;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    // raise trigger; lat = edges after the first sampling edge until glitch_en, -1 if none
    task automatic trig_and_wait(output int lat);
        lat = -1;
        @(negedge clk);
        trigger = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (glitch_en) begin
                lat = n;
                break;
            end
        end
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; trigger = 1'b0;
        delay_start = '0; delay_end = '0; delay_step = '0;
        width_start = '0; width_end = '0; width_step = '0;
        mode_in = '0; model_on = 1'b1; man_rdy = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({glitch_en, busy, done, err, glitch_delay, glitch_width, glitch_mode, attempt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%0b busy=%0b done=%0b err=%0b d=%0d w=%0d m=%0h cnt=%0d, required all 0",
                     glitch_en, busy, done, err, glitch_delay, glitch_width, glitch_mode, attempt_cnt);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sweep_2d();
        int lat;
        int d0;
        int f0;
        d0 = done_cnt; f0 = fire_cnt;
        model_on = 1'b1;
        do_start(16'd10, 16'd30, 16'd10, 8'd2, 8'd4, 8'd2, 8'hA5);
        checks++;
        if (busy !== 1'b1 || glitch_delay !== 16'd10 || glitch_width !== 8'd2 || attempt_cnt !== 24'd0) begin
            errors++;
            $display("FAIL sweep_start: busy=%0b d=%0d w=%0d cnt=%0d, required 1 10 2 0",
                     busy, glitch_delay, glitch_width, attempt_cnt);
        end
        for (int wi = 0; wi < 2; wi++) begin
            for (int di = 0; di < 3; di++) begin
                push_exp(10 + 10 * di, 2 + 2 * wi, 8'hA5);
                trig_and_wait(lat);
                checks++;
                if (lat != TRIG_SYNC) begin
                    errors++;
                    $display("FAIL sweep_latency: got %0d, required %0d", lat, TRIG_SYNC);
                end
                repeat (8) @(negedge clk);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || attempt_cnt !== 24'd6 || fire_cnt - f0 != 6) begin
            errors++;
            $display("FAIL sweep_end: done=%0d busy=%0b cnt=%0d fires=%0d, required 1 0 6 6",
                     done_cnt - d0, busy, attempt_cnt, fire_cnt - f0);
        end
        checks++;
        if (glitch_delay !== 16'd10 || glitch_width !== 8'd4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL sweep_hold: d=%0d w=%0d pending=%0d, required 10 4 0",
                     glitch_delay, glitch_width, exp_q.size());
        end
    endtask

    task automatic test_no_wrap();
        int lat;
        int d0;
        d0 = done_cnt;
        model_on = 1'b1;
        do_start(16'd65530, 16'd65535, 16'd4, 8'd1, 8'd1, 8'd0, 8'h11);
        push_exp(65530, 1, 8'h11);
        trig_and_wait(lat);
        repeat (8) @(negedge clk);
        push_exp(65534, 1, 8'h11);
        trig_and_wait(lat);
        repeat (8) @(negedge clk);
        trig_and_wait(lat);
        checks++;
        if (lat != -1) begin
            errors++;
            $display("FAIL nowrap_extra_fire: latency=%0d, required -1 (no fire)", lat);
        end
        checks++;
        if (done_cnt - d0 != 1 || attempt_cnt !== 24'd2 || busy !== 1'b0 ||
            glitch_delay !== 16'd65530 || glitch_width !== 8'd1) begin
            errors++;
            $display("FAIL nowrap_end: done=%0d cnt=%0d busy=%0b d=%0d w=%0d, required 1 2 0 65530 1",
                     done_cnt - d0, attempt_cnt, busy, glitch_delay, glitch_width);
        end
    endtask

    task automatic test_bad_config();
        int lat;
        int e0;
        int f0;
        e0 = err_cyc; f0 = fire_cnt;
        do_start(16'd9, 16'd5, 16'd1, 8'd0, 8'd0, 8'd0, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (err_cyc - e0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badcfg_delay: err_cycles=%0d busy=%0b, required 1 0", err_cyc - e0, busy);
        end
        do_start(16'd0, 16'd5, 16'd1, 8'd6, 8'd5, 8'd1, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (err_cyc - e0 != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badcfg_width: err_cycles=%0d busy=%0b, required 2 0", err_cyc - e0, busy);
        end
        trig_and_wait(lat);
        checks++;
        if (lat != -1 || fire_cnt != f0) begin
            errors++;
            $display("FAIL badcfg_fire: latency=%0d fires=%0d, required -1 0", lat, fire_cnt - f0);
        end
    endtask

    task automatic test_ready_drop();
        int lat;
        int d0;
        int f0;
        d0 = done_cnt; f0 = fire_cnt;
        model_on = 1'b0;
        man_rdy  = 1'b0;
        do_start(16'd100, 16'd100, 16'd0, 8'd5, 8'd5, 8'd0, 8'h3C);
        trig_and_wait(lat);
        checks++;
        if (lat != -1) begin
            errors++;
            $display("FAIL drop_not_ready: latency=%0d, required -1 (no fire)", lat);
        end
        repeat (4) @(negedge clk);
        man_rdy = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (fire_cnt != f0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_no_queue: fires=%0d busy=%0b, required 0 1", fire_cnt - f0, busy);
        end
        push_exp(100, 5, 8'h3C);
        trig_and_wait(lat);
        checks++;
        if (lat != TRIG_SYNC) begin
            errors++;
            $display("FAIL drop_latency: got %0d, required %0d", lat, TRIG_SYNC);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || attempt_cnt !== 24'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_end: done=%0d cnt=%0d busy=%0b, required 1 1 0",
                     done_cnt - d0, attempt_cnt, busy);
        end
    endtask

    task automatic test_abort();
        int lat;
        int d0;
        d0 = done_cnt;
        model_on = 1'b0;
        man_rdy  = 1'b1;
        do_start(16'd10, 16'd30, 16'd10, 8'd2, 8'd2, 8'd0, 8'h5A);
        push_exp(10, 2, 8'h5A);
        trig_and_wait(lat);
        man_rdy = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (lat != TRIG_SYNC || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait: latency=%0d busy=%0b, required %0d 0", lat, busy, TRIG_SYNC);
        end
        man_rdy = 1'b1;
        repeat (8) @(negedge clk);
        trig_and_wait(lat);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || lat != -1) begin
            errors++;
            $display("FAIL abort_idle: done=%0d busy=%0b latency=%0d, required 0 0 -1",
                     done_cnt - d0, busy, lat);
        end
        do_start(16'd10, 16'd30, 16'd10, 8'd2, 8'd2, 8'd0, 8'h5A);
        checks++;
        if (busy !== 1'b1 || glitch_delay !== 16'd10 || glitch_width !== 8'd2 || attempt_cnt !== 24'd0) begin
            errors++;
            $display("FAIL abort_restart: busy=%0b d=%0d w=%0d cnt=%0d, required 1 10 2 0",
                     busy, glitch_delay, glitch_width, attempt_cnt);
        end
        push_exp(10, 2, 8'h5A);
        trig_and_wait(lat);
        repeat (4) @(negedge clk);
        checks++;
        if (attempt_cnt !== 24'd1 || glitch_delay !== 16'd20) begin
            errors++;
            $display("FAIL abort_resume: cnt=%0d d=%0d, required 1 20", attempt_cnt, glitch_delay);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_arm: busy=%0b done=%0d, required 0 0", busy, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid_fire();
        int  lat;
        bit  seen;
        model_on = 1'b1;
        do_start(16'd40, 16'd40, 16'd0, 8'd7, 8'd7, 8'd0, 8'h03);
        push_exp(40, 7, 8'h03);
        @(negedge clk);
        trigger = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (glitch_en) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_prefire: glitch_en=0, required a fire before reset");
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({glitch_en, busy, done, err, glitch_delay, glitch_width, glitch_mode, attempt_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_async: en=%0b busy=%0b d=%0d w=%0d m=%0h cnt=%0d, required all 0",
                     glitch_en, busy, glitch_delay, glitch_width, glitch_mode, attempt_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        trigger = 1'b0;
        repeat (4) @(negedge clk);
        trig_and_wait(lat);
        checks++;
        if (lat != -1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: latency=%0d busy=%0b, required -1 0", lat, busy);
        end
        do_start(16'd40, 16'd40, 16'd0, 8'd7, 8'd7, 8'd0, 8'h03);
        push_exp(40, 7, 8'h03);
        trig_and_wait(lat);
        repeat (8) @(negedge clk);
        checks++;
        if (lat != TRIG_SYNC || attempt_cnt !== 24'd1 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_recover: latency=%0d cnt=%0d busy=%0b pending=%0d, required %0d 1 0 0",
                     lat, attempt_cnt, busy, exp_q.size(), TRIG_SYNC);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        done_cnt = 0; err_cyc = 0; fire_cnt = 0;
        test_reset();
        test_sweep_2d();
        test_no_wrap();
        test_bad_config();
        test_ready_drop();
        test_abort();
        test_reset_mid_fire();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_points: %0d expected fires never seen, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
